// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if
//   Command/response channel between a client (CPU stub, DMA, sequencer)
//   and mem_bus_master.
//
//   Signals:
//     cmd_valid  client -> block  command request
//     cmd_ready  block  -> client block is idle and can take a command
//     cmd_write  client -> block  1 = write, 0 = read
//     cmd_addr   client -> block  word address
//     cmd_wdata  client -> block  write data
//     rsp_valid  block  -> client one-cycle read-data strobe
//     rsp_rdata  block  -> client last captured read data
//     busy       block  -> client block is not idle
//     verify_err block  -> client sticky write-verify mismatch
//
//   Modports:
//     master  the client that issues commands
//     slave   mem_bus_master, which services them
interface mem_bus_master_if #(
  parameter int width      = 8,
  parameter int addr_width = 5
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [addr_width-1:0] cmd_addr;
  logic [width-1:0]      cmd_wdata;
  logic                  rsp_valid;
  logic [width-1:0]      rsp_rdata;
  logic                  busy;
  logic                  verify_err;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, busy, verify_err
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, busy, verify_err
  );
endinterface

// File: rtl/mem_bus_master.sv
// mem_bus_master
//   Initiator for a single-port shared-bus memory (wen/ren strobes, address,
//   one bidirectional tristate data bus). Takes single-word read/write
//   commands on a valid/ready channel, sequences the memory strobes, owns the
//   data-bus turnaround and returns read data on a one-cycle response strobe.
//
//   Ports:
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset
//     cmd       mem_bus_master_if.slave: cmd_valid/ready/write/addr/wdata,
//               rsp_valid/rsp_rdata, busy, verify_err
//     mem_wen   memory write strobe
//     mem_ren   memory read strobe
//     mem_addr  memory address
//     mem_data  shared data bus, driven only in WRITE, otherwise high-Z
//
//   Optional feature, macro MEM_MASTER_VERIFY_EN:
//     every write is read back (WRITE, TURN, RD_ADDR, RD_DATA, TURN) and a
//     mismatch sets the sticky verify_err flag. Without the macro verify_err
//     is tied low and WRITE returns straight to IDLE.
module mem_bus_master #(
  parameter int width      = 8,
  parameter int size       = 32,
  parameter int addr_width = $clog2(size)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_bus_master_if.slave       cmd,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [addr_width-1:0] mem_addr,
  inout  wire  [width-1:0]      mem_data
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_DATA,
    TURN
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [addr_width-1:0] addr_q;
  logic [width-1:0]      wdata_q;
  logic [width-1:0]      rdata_q;
  logic                  write_q;
  logic                  drive_en;
  logic                  accept;

`ifdef MEM_MASTER_VERIFY_EN
  // Set once the read-back of the current write has been captured, so the
  // second TURN of a verified write goes home instead of reading again.
  logic                  verify_done;
  logic                  err_q;
`endif

  assign accept = cmd.cmd_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = cmd.cmd_write ? WRITE : RD_ADDR;
`ifdef MEM_MASTER_VERIFY_EN
      WRITE:   state_next = TURN;
`else
      WRITE:   state_next = IDLE;
`endif
      RD_ADDR: state_next = RD_DATA;
      RD_DATA: state_next = TURN;
`ifdef MEM_MASTER_VERIFY_EN
      TURN:    state_next = (write_q && !verify_done) ? RD_ADDR : IDLE;
`else
      TURN:    state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Everything facing the memory is decoded from state and addr_q only, so
  // cmd_* never reaches mem_* combinationally. rsp_valid falls out of TURN
  // following a plain read; verify reads carry write_q = 1 and stay silent.
  always_comb begin
    mem_wen       = 1'b0;
    mem_ren       = 1'b0;
    mem_addr      = '0;
    drive_en      = 1'b0;
    cmd.cmd_ready = 1'b0;
    cmd.busy      = 1'b1;
    cmd.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd.cmd_ready = 1'b1;
        cmd.busy      = 1'b0;
      end
      WRITE: begin
        mem_wen  = 1'b1;
        mem_addr = addr_q;
        drive_en = 1'b1;
      end
      RD_ADDR, RD_DATA: begin
        mem_ren  = 1'b1;
        mem_addr = addr_q;
      end
      TURN: begin
        cmd.rsp_valid = !write_q;
      end
      default: ;
    endcase
  end

  assign mem_data      = drive_en ? wdata_q : 'z;
  assign cmd.rsp_rdata = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= cmd.cmd_addr;
        wdata_q <= cmd.cmd_wdata;
        write_q <= cmd.cmd_write;
      end
      if (state == RD_DATA && !write_q) begin
        rdata_q <= mem_data;
      end
    end
  end

`ifdef MEM_MASTER_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      verify_done <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        verify_done <= 1'b0;
      end else if (state == RD_DATA && write_q) begin
        verify_done <= 1'b1;
        if (mem_data != wdata_q) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign cmd.verify_err = err_q;
`else
  assign cmd.verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master
//   Self-checking bench for mem_bus_master. Contains a behavioural model of
//   the shared-bus memory (output buffer loaded on the first read-strobe
//   cycle, driven on the second) and a reference model of the expected
//   memory contents, read data, latencies and verify flag. The data bus is a
//   pulled-up net, so a released bus reads as all ones.
//   Honours MEM_MASTER_VERIFY_EN when it is defined for the whole build.
module tb_mem_bus_master;

  localparam int WIDTH = 8;
  localparam int SIZE  = 32;
  localparam int AW    = 5;
`ifdef MEM_MASTER_VERIFY_EN
  localparam bit verify_on = 1'b1;
`else
  localparam bit verify_on = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mem_wen;
  logic            mem_ren;
  logic [AW-1:0]   mem_addr;
  tri1 [WIDTH-1:0] mem_data;

  mem_bus_master_if #(.width(WIDTH), .addr_width(AW)) bus ();

  mem_bus_master #(.width(WIDTH), .size(SIZE), .addr_width(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd      (bus),
    .mem_wen  (mem_wen),
    .mem_ren  (mem_ren),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  // Memory model; corrupt flips bit 0 of every stored word.
  logic [WIDTH-1:0] mem_array [SIZE];
  logic [WIDTH-1:0] mem_obuf;
  logic             mem_oe;
  bit               corrupt;

  assign mem_data = mem_oe ? mem_obuf : 'z;

  always @(posedge clk) begin
    if (mem_wen) mem_array[mem_addr] <= corrupt ? (mem_data ^ 8'h01) : mem_data;
    if (!rst_n) begin
      mem_oe <= 1'b0;
    end else if (mem_ren && !mem_oe) begin
      mem_obuf <= mem_array[mem_addr];
      mem_oe   <= 1'b1;
    end else begin
      mem_oe <= 1'b0;
    end
  end

  // Reference model state.
  logic [WIDTH-1:0] ref_mem [SIZE];
  logic [WIDTH-1:0] exp_rdata;
  bit               exp_err;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Bus monitor: strobes exclusive, ready low while busy, and when neither
  // end drives the data bus it must read as released (pull-up value).
  always @(negedge clk) begin
    checkOutput("wen_ren_exclusive", 32'(mem_wen & mem_ren), 0);
    if (bus.busy) checkOutput("ready_low_when_busy", 32'(bus.cmd_ready), 0);
    if (!mem_wen && !mem_oe) checkOutput("bus_released", 32'(mem_data), 32'hFF);
  end

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_wen"},   32'(mem_wen), 0);
    checkOutput({tag, "_ren"},   32'(mem_ren), 0);
    checkOutput({tag, "_addr"},  32'(mem_addr), 0);
    checkOutput({tag, "_data"},  32'(mem_data), 32'hFF);
    checkOutput({tag, "_ready"}, 32'(bus.cmd_ready), 1);
    checkOutput({tag, "_rsp"},   32'(bus.rsp_valid), 0);
    checkOutput({tag, "_busy"},  32'(bus.busy), 0);
  endtask

  task automatic waitReady();
    int waited = 0;
    while (!bus.cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("accept_wait", 32'(waited < 20), 1);
  endtask

  // Issues one command and follows it to the next cmd_ready. Sample j is
  // taken 1 time unit after the j-th edge following the accept edge.
  // Expected: write ready again at j=1 (j=5 with read-back), read at j=3;
  // a read pulses rsp_valid once at j=2, i.e. the third edge counting the
  // accept edge. With hold set the command stays valid while busy.
  task automatic applyStimulus(input bit wr, input logic [AW-1:0] a, input logic [WIDTH-1:0] d, input bit hold);
    int pulses = 0;
    int pulse_j = -1;
    int wen_cycles = 0;
    int j_ready = -1;
    logic [WIDTH-1:0] pulse_data = '0;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_valid = 1'b1;
    waitReady();
    @(posedge clk);
    #1;
    if (!hold) bus.cmd_valid = 1'b0;
    if (wr) begin
      ref_mem[a] = corrupt ? (d ^ 8'h01) : d;
      if (corrupt && verify_on) exp_err = 1'b1;
    end
    for (int j = 0; j < 12; j++) begin
      if (mem_wen) begin
        wen_cycles++;
        checkOutput("wen_data", 32'(mem_data), 32'(d));
        checkOutput("wen_addr", 32'(mem_addr), 32'(a));
      end
      if (mem_ren) checkOutput("ren_addr", 32'(mem_addr), 32'(a));
      if (bus.rsp_valid) begin
        pulses++;
        pulse_j    = j;
        pulse_data = bus.rsp_rdata;
      end
      if (bus.cmd_ready) begin
        j_ready = j;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("ready_latency", 32'(j_ready), wr ? (verify_on ? 5 : 1) : 3);
    checkOutput("wen_cycles", 32'(wen_cycles), wr ? 1 : 0);
    checkOutput("rsp_pulses", 32'(pulses), wr ? 0 : 1);
    if (!wr) begin
      checkOutput("rsp_edge", 32'(pulse_j), 2);
      checkOutput("rsp_rdata", 32'(pulse_data), 32'(ref_mem[a]));
      exp_rdata = ref_mem[a];
    end
    checkOutput("rdata_hold", 32'(bus.rsp_rdata), 32'(exp_rdata));
    checkOutput("verify_err", 32'(bus.verify_err), 32'(exp_err));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    corrupt       = 1'b0;
    exp_rdata     = '0;
    exp_err       = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    checkIdle("in_reset");
    checkOutput("in_reset_rdata", 32'(bus.rsp_rdata), 0);
    checkOutput("in_reset_verr", 32'(bus.verify_err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkIdle("after_reset");

    // Single write then read back
    applyStimulus(1'b1, 5'd5, 8'hA5, 1'b0);
    applyStimulus(1'b0, 5'd5, 8'h00, 1'b0);

    // Fill every address, read back in reverse order
    for (int i = 0; i < SIZE; i++) applyStimulus(1'b1, AW'(i), 8'(i) ^ 8'h3C, 1'b0);
    for (int i = SIZE - 1; i >= 0; i--) applyStimulus(1'b0, AW'(i), 8'h00, 1'b0);

    // cmd_valid held high across alternating write/read pairs
    for (int k = 0; k < 6; k++) begin
      logic [AW-1:0]    a;
      logic [WIDTH-1:0] d;
      a = AW'($urandom_range(0, SIZE - 1));
      d = 8'($urandom);
      applyStimulus(1'b1, a, d, 1'b1);
      applyStimulus(1'b0, a, 8'($urandom), 1'b1);
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);

    // Reset during RD_DATA of a read from addr 7
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 5'd7;
    bus.cmd_wdata = '0;
    bus.cmd_valid = 1'b1;
    waitReady();
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("pre_abort_ren", 32'(mem_ren), 1);
    rst_n = 1'b0;
    #1;
    exp_rdata = '0;
    exp_err   = 1'b0;
    checkOutput("abort_rd_ren", 32'(mem_ren), 0);
    checkOutput("abort_rd_addr", 32'(mem_addr), 0);
    checkOutput("abort_rd_busy", 32'(bus.busy), 0);
    checkOutput("abort_rd_ready", 32'(bus.cmd_ready), 1);
    checkOutput("abort_rd_rdata", 32'(bus.rsp_rdata), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput("abort_rd_no_rsp", 32'(bus.rsp_valid), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 5'd7, 8'h00, 1'b0);

    // Reset during WRITE must release the bus at once
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 5'd9;
    bus.cmd_wdata = 8'h96;
    bus.cmd_valid = 1'b1;
    waitReady();
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    checkOutput("pre_abort_drive", 32'(mem_data), 32'h96);
    rst_n = 1'b0;
    #1;
    exp_rdata = '0;
    exp_err   = 1'b0;
    checkOutput("abort_wr_release", 32'(mem_data), 32'hFF);
    checkOutput("abort_wr_wen", 32'(mem_wen), 0);
    checkOutput("abort_wr_addr", 32'(mem_addr), 0);
    checkOutput("abort_wr_busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 5'd9, 8'h42, 1'b0);
    applyStimulus(1'b0, 5'd9, 8'h00, 1'b0);

    // Random mixed traffic
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, SIZE - 1)),
                    8'($urandom), 1'($urandom_range(0, 1)));
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);

`ifdef MEM_MASTER_VERIFY_EN
    // Clean verified write, then a corrupted one; the flag must stick
    applyStimulus(1'b1, 5'd3, 8'h5A, 1'b0);
    corrupt = 1'b1;
    applyStimulus(1'b1, 5'd4, 8'h66, 1'b0);
    corrupt = 1'b0;
    applyStimulus(1'b0, 5'd4, 8'h00, 1'b0);
    applyStimulus(1'b1, 5'd6, 8'h11, 1'b0);
    applyStimulus(1'b0, 5'd3, 8'h00, 1'b0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
